execute: RTL and testbench
==========================

// Module: execute
// PURPOSE
//   EX stage of the 5-stage RV32I pipeline. Holds the ID/EX register that captures decode-stage control and datapath outputs.
//   Applies operand forwarding, runs the ALU and resolves branches/jumps.
//   Produces redirect (PCSrcE, PCTargetE) for fetch and EX results for the EX/MEM register.
// PARAMETERS
//   XLEN  32  datapath width
// PORTS
//   clk          in   1     clock, rising edge
//   rst          in   1     synchronous reset, active-low (0 = reset)
//   FlushE       in   1     hazard unit: load bubble into ID/EX on next edge
//   RegWriteD    in   1     decode control
//   MemWriteD    in   1     decode control
//   ResultSrcD   in   2     decode control (00 ALU, 01 mem, 10 PC+4)
//   JumpD        in   1     decode control (JAL)
//   BranchD      in   1     decode control (BEQ)
//   ALUControlD  in   3     riscv_pkg::alu_op_e
//   ALUSrcD      in   1     0: SrcB = fwd RD2, 1: SrcB = ExtImm
//   RD1D,RD2D    in   XLEN  register file read data
//   PCD,PCPlus4D in   XLEN  instruction PC, PC+4
//   ExtImmD      in   XLEN  extended immediate
//   Rs1D,Rs2D,RdD in  5     register indices
//   ForwardAE    in   2     SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
//   ForwardBE    in   2     WriteData select, same encoding
//   ALUResultM   in   XLEN  MEM-stage forward value
//   ResultW      in   XLEN  WB-stage forward value
//   ALUResultE   out  XLEN  ALU result
//   WriteDataE   out  XLEN  forwarded RD2 (store data)
//   PCTargetE    out  XLEN  PCE + ExtImmE
//   PCSrcE       out  1     1 = redirect fetch to PCTargetE
//   RegWriteE,MemWriteE out 1  registered control (to EX/MEM, hazard unit)
//   ResultSrcE   out  2     registered control
//   Rs1E,Rs2E,RdE out 5     registered indices (hazard unit)
//   PCPlus4E     out  XLEN  registered PC+4
// BEHAVIOUR
//   - ID/EX register: all *D inputs captured every rising edge; there is no stall input.
//   - Priority on each edge: rst==0 > FlushE==1 > capture.
//   - Reset and flush both clear every ID/EX field to 0. The result is a bubble: no write, no branch, no jump, ADD op.
//   - All outputs are combinational from the ID/EX registers plus the forward inputs. All outputs = 0 after reset, except:
//     - ALUResultE = 0
//     - WriteDataE = RD2E = 0
//     - PCTargetE = 0
//   - Latency: 1 cycle from D inputs to E outputs. Forward inputs act in the same cycle.
//   - Forward mux: 00 → RD*E, 01 → ResultW, 10 → ALUResultM, 11 → RD*E (reserved).
//   - SrcA = fwdA. SrcB = ALUSrcE ? ExtImmE : fwdB. WriteDataE = fwdB regardless of ALUSrcE.
//   - ALU ops, all mod 2^XLEN:
//     - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
//     - 101 SLT: signed compare, result 1 or 0, zero-extended
//     - 110 SLL, 111 SRL: shift amount = SrcB[4:0]
//   - ZeroE = (ALUResultE == 0).
//   - PCSrcE = (BranchE & ZeroE) | JumpE.
//   - PCTargetE = PCE + ExtImmE, wrapping; no JALR path.
//   - Overflow is ignored on ADD/SUB. SLT is correct across the sign boundary (0x7FFFFFFF vs 0x80000000).
//   - FlushE and rst==0 in the same cycle: reset wins; the result is identical (all zero).
//   - Reset mid-stream: the instruction in ID/EX is lost. PCSrcE = 0 in the cycle after the reset edge.
// TESTING
//   - Reset: rst=0 for one edge with nonzero D inputs
//     -> all outputs 0; PCSrcE = 0.
//   - ADD/SUB/SLT with ALUSrcD=0, forwards 00:
//     - RD1 = 5, RD2 = 7 -> ADD 12; SUB 0xFFFFFFFE
//     - RD1 = 0x80000000, RD2 = 1 -> SLT 1
//   - Forwarding, with RD1D = 1, ALUResultM = 0x10, ResultW = 0x20, ADD, ExtImm = 0, ALUSrc = 1:
//     - ForwardAE = 10 -> 0x10; 01 -> 0x20; 11 -> 1
//   - BEQ, PCD = 0x100, ExtImmD = 0xFFFFFFF8, fwd operands 9 and 9, SUB:
//     - PCSrcE = 1, PCTargetE = 0xF8
//     - operands 9 and 8 -> PCSrcE = 0
//   - Flush: JumpD = 1 and FlushE = 1 at the same edge
//     -> next cycle PCSrcE = 0, RegWriteE = 0, MemWriteE = 0.
//   - Store: ALUSrcD = 1, ExtImm = 4, RD1 = 0x1000, ForwardBE = 10 with ALUResultM = 0xAB
//     -> ALUResultE = 0x1004, WriteDataE = 0xAB.

Source files
------------

// File: rtl/execute.sv
// EX stage of the RV32I pipeline: ID/EX register, operand forwarding, ALU and
// branch/jump resolution feeding fetch redirect and the EX/MEM register.
module execute #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            FlushE,
   input  logic            RegWriteD,
   input  logic            MemWriteD,
   input  logic [1:0]      ResultSrcD,
   input  logic            JumpD,
   input  logic            BranchD,
   input  logic [2:0]      ALUControlD,
   input  logic            ALUSrcD,
   input  logic [XLEN-1:0] RD1D,
   input  logic [XLEN-1:0] RD2D,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic [XLEN-1:0] ExtImmD,
   input  logic [4:0]      Rs1D,
   input  logic [4:0]      Rs2D,
   input  logic [4:0]      RdD,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] ResultW,
   output logic [XLEN-1:0] ALUResultE,
   output logic [XLEN-1:0] WriteDataE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            PCSrcE,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic [1:0]      ResultSrcE,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic [XLEN-1:0] PCPlus4E
);

   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                          OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SLT = 3'b101,
                          OP_SLL = 3'b110, OP_SRL = 3'b111;

   typedef struct packed {
      logic            RegWrite;
      logic            MemWrite;
      logic [1:0]      ResultSrc;
      logic            Jump;
      logic            Branch;
      logic [2:0]      ALUControl;
      logic            ALUSrc;
      logic [XLEN-1:0] RD1;
      logic [XLEN-1:0] RD2;
      logic [XLEN-1:0] PC;
      logic [XLEN-1:0] PCPlus4;
      logic [XLEN-1:0] ExtImm;
      logic [4:0]      Rs1;
      logic [4:0]      Rs2;
      logic [4:0]      Rd;
   } idex_t;

   idex_t idex_q, idex_d;

   always_comb begin
      idex_d            = '0;
      idex_d.RegWrite   = RegWriteD;
      idex_d.MemWrite   = MemWriteD;
      idex_d.ResultSrc  = ResultSrcD;
      idex_d.Jump       = JumpD;
      idex_d.Branch     = BranchD;
      idex_d.ALUControl = ALUControlD;
      idex_d.ALUSrc     = ALUSrcD;
      idex_d.RD1        = RD1D;
      idex_d.RD2        = RD2D;
      idex_d.PC         = PCD;
      idex_d.PCPlus4    = PCPlus4D;
      idex_d.ExtImm     = ExtImmD;
      idex_d.Rs1        = Rs1D;
      idex_d.Rs2        = Rs2D;
      idex_d.Rd         = RdD;
   end

   // An all-zero ID/EX entry is a bubble: ADD, no write, no branch, no jump.
   always_ff @(posedge clk) begin
      if (!rst)        idex_q <= '0;
      else if (FlushE) idex_q <= '0;
      else             idex_q <= idex_d;
   end

   function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel,
                                                 input logic [XLEN-1:0] rd,
                                                 input logic [XLEN-1:0] resw,
                                                 input logic [XLEN-1:0] alum);
      case (sel)
         2'b01:   fwd_sel = resw;
         2'b10:   fwd_sel = alum;
         default: fwd_sel = rd;
      endcase
   endfunction

   logic [XLEN-1:0] src_a, src_b, fwd_b;
   logic            zero;

   assign src_a = fwd_sel(ForwardAE, idex_q.RD1, ResultW, ALUResultM);
   assign fwd_b = fwd_sel(ForwardBE, idex_q.RD2, ResultW, ALUResultM);
   assign src_b = idex_q.ALUSrc ? idex_q.ExtImm : fwd_b;

   always_comb begin
      ALUResultE = '0;
      case (idex_q.ALUControl)
         OP_ADD: ALUResultE = src_a + src_b;
         OP_SUB: ALUResultE = src_a - src_b;
         OP_AND: ALUResultE = src_a & src_b;
         OP_OR:  ALUResultE = src_a | src_b;
         OP_XOR: ALUResultE = src_a ^ src_b;
         OP_SLT: ALUResultE = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_SLL: ALUResultE = src_a << src_b[4:0];
         OP_SRL: ALUResultE = src_a >> src_b[4:0];
         default: ALUResultE = '0;
      endcase
   end

   assign zero       = (ALUResultE == '0);
   assign PCSrcE     = (idex_q.Branch & zero) | idex_q.Jump;
   assign PCTargetE  = idex_q.PC + idex_q.ExtImm;
   assign WriteDataE = fwd_b;
   assign RegWriteE  = idex_q.RegWrite;
   assign MemWriteE  = idex_q.MemWrite;
   assign ResultSrcE = idex_q.ResultSrc;
   assign Rs1E       = idex_q.Rs1;
   assign Rs2E       = idex_q.Rs2;
   assign RdE        = idex_q.Rd;
   assign PCPlus4E   = idex_q.PCPlus4;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the EX stage: expected results are queued as each
// instruction is driven and compared once it sits in ID/EX.
module tb_execute;

   logic        clk = 1'b0;
   logic        rst, FlushE, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
   logic [1:0]  ResultSrcD, ForwardAE, ForwardBE;
   logic [2:0]  ALUControlD;
   logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ExtImmD, ALUResultM, ResultW;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic [31:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
   logic        PCSrcE, RegWriteE, MemWriteE;
   logic [1:0]  ResultSrcE;
   logic [4:0]  Rs1E, Rs2E, RdE;

   execute #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .FlushE(FlushE),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
      .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
      .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ExtImmD(ExtImmD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ALUResultM(ALUResultM), .ResultW(ResultW),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
      .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .PCPlus4E(PCPlus4E)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] tgt;
      logic        pcsrc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic asrc,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic br, input logic jmp,
                        input logic [1:0] fa, input logic [1:0] fb);
      rst = 1'b1; FlushE = 1'b0;
      RegWriteD = 1'b1; MemWriteD = 1'b0; ResultSrcD = 2'b10;
      ALUControlD = op; ALUSrcD = asrc; RD1D = rd1; RD2D = rd2;
      ExtImmD = imm; PCD = pc; PCPlus4D = pc + 32'd4;
      BranchD = br; JumpD = jmp; ForwardAE = fa; ForwardBE = fb;
      Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
   endtask

   task automatic expect_push(input logic [31:0] alu, input logic [31:0] wd,
                              input logic [31:0] tgt, input logic pcsrc);
      exp_t e;
      e.alu = alu; e.wd = wd; e.tgt = tgt; e.pcsrc = pcsrc;
      sb.push_back(e);
   endtask

   task automatic cyc(input string tag);
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s scoreboard empty got=0x%08h exp=entry", tag, ALUResultE);
      end else begin
         e = sb.pop_front();
         chk({tag, ".alu"},   ALUResultE, e.alu);
         chk({tag, ".wd"},    WriteDataE, e.wd);
         chk({tag, ".tgt"},   PCTargetE,  e.tgt);
         chk({tag, ".pcsrc"}, {31'b0, PCSrcE}, {31'b0, e.pcsrc});
      end
   endtask

   task automatic chk_ctrl_zero(input string tag);
      chk({tag, ".regw"}, {31'b0, RegWriteE}, 32'd0);
      chk({tag, ".memw"}, {31'b0, MemWriteE}, 32'd0);
      chk({tag, ".rsrc"}, {30'b0, ResultSrcE}, 32'd0);
      chk({tag, ".idx"},  {17'b0, Rs1E, Rs2E, RdE}, 32'd0);
      chk({tag, ".pc4"},  PCPlus4E, 32'd0);
   endtask

   initial begin
      ALUResultM = 32'h0; ResultW = 32'h0;

      // reset with nonzero D inputs (including a jump)
      drive(3'b000, 1'b0, 32'd5, 32'd7, 32'd8, 32'h100, 1'b1, 1'b1, 2'b00, 2'b00);
      MemWriteD = 1'b1; rst = 1'b0;
      expect_push(32'h0, 32'h0, 32'h0, 1'b0);
      cyc("reset");
      chk_ctrl_zero("reset");

      drive(3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'h200, 1'b0, 1'b0, 2'b00, 2'b00);
      expect_push(32'd12, 32'd7, 32'h200, 1'b0);
      cyc("add");
      chk("add.regw", {31'b0, RegWriteE}, 32'd1);
      chk("add.rsrc", {30'b0, ResultSrcE}, 32'd2);
      chk("add.idx",  {17'b0, Rs1E, Rs2E, RdE}, {17'b0, 5'd1, 5'd2, 5'd3});
      chk("add.pc4",  PCPlus4E, 32'h204);

      drive(3'b001, 1'b0, 32'd5, 32'd7, 32'd0, 32'h200, 1'b0, 1'b0, 2'b00, 2'b00);
      expect_push(32'hFFFF_FFFE, 32'd7, 32'h200, 1'b0);
      cyc("sub");

      drive(3'b101, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
      expect_push(32'd1, 32'd1, 32'h0, 1'b0);
      cyc("slt_neg");

      drive(3'b101, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
      expect_push(32'd0, 32'h8000_0000, 32'h0, 1'b0);
      cyc("slt_pos");

      // logic and shift ops; shift amount uses only SrcB[4:0]
      drive(3'b010, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
      expect_push(32'h00F0_000F, 32'h0FF0_0F0F, 32'h0, 1'b0);
      cyc("and");
      drive(3'b011, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
      expect_push(32'hFFF0_0FFF, 32'h0FF0_0F0F, 32'h0, 1'b0);
      cyc("or");
      drive(3'b100, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
      expect_push(32'hFF00_0FF0, 32'h0FF0_0F0F, 32'h0, 1'b0);
      cyc("xor");
      drive(3'b110, 1'b0, 32'h8000_0001, 32'h24, 32'd0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
      expect_push(32'h0000_0010, 32'h24, 32'h0, 1'b0);
      cyc("sll");
      drive(3'b111, 1'b0, 32'h8000_0001, 32'h24, 32'd0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
      expect_push(32'h0800_0000, 32'h24, 32'h0, 1'b0);
      cyc("srl");

      // forwarding on SrcA
      ALUResultM = 32'h10; ResultW = 32'h20;
      drive(3'b000, 1'b1, 32'd1, 32'd0, 32'd0, 32'h300, 1'b0, 1'b0, 2'b10, 2'b00);
      expect_push(32'h10, 32'h0, 32'h300, 1'b0);
      cyc("fwdA_10");
      drive(3'b000, 1'b1, 32'd1, 32'd0, 32'd0, 32'h300, 1'b0, 1'b0, 2'b01, 2'b00);
      expect_push(32'h20, 32'h0, 32'h300, 1'b0);
      cyc("fwdA_01");
      drive(3'b000, 1'b1, 32'd1, 32'd0, 32'd0, 32'h300, 1'b0, 1'b0, 2'b11, 2'b00);
      expect_push(32'h1, 32'h0, 32'h300, 1'b0);
      cyc("fwdA_11");

      // BEQ with both operands forwarded
      ALUResultM = 32'd9; ResultW = 32'd9;
      drive(3'b001, 1'b0, 32'd3, 32'd4, 32'hFFFF_FFF8, 32'h100, 1'b1, 1'b0, 2'b10, 2'b01);
      expect_push(32'd0, 32'd9, 32'hF8, 1'b1);
      cyc("beq_taken");
      ResultW = 32'd8;
      drive(3'b001, 1'b0, 32'd3, 32'd4, 32'hFFFF_FFF8, 32'h100, 1'b1, 1'b0, 2'b10, 2'b01);
      expect_push(32'd1, 32'd8, 32'hF8, 1'b0);
      cyc("beq_not");

      // flush bubbles a jump
      ALUResultM = 32'h0; ResultW = 32'h0;
      drive(3'b000, 1'b0, 32'd5, 32'd7, 32'h40, 32'h100, 1'b0, 1'b1, 2'b00, 2'b00);
      MemWriteD = 1'b1; FlushE = 1'b1;
      expect_push(32'h0, 32'h0, 32'h0, 1'b0);
      cyc("flush");
      chk_ctrl_zero("flush");

      // store: address from imm, data forwarded from MEM
      ALUResultM = 32'hAB;
      drive(3'b000, 1'b1, 32'h1000, 32'h55, 32'd4, 32'h0, 1'b0, 1'b0, 2'b00, 2'b10);
      MemWriteD = 1'b1; RegWriteD = 1'b0;
      expect_push(32'h1004, 32'hAB, 32'h4, 1'b0);
      cyc("store");
      chk("store.memw", {31'b0, MemWriteE}, 32'd1);
      chk("store.regw", {31'b0, RegWriteE}, 32'd0);

      // JAL with wrapping target
      ALUResultM = 32'h0;
      drive(3'b000, 1'b0, 32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0, 1'b0, 1'b1, 2'b00, 2'b00);
      expect_push(32'h0, 32'h0, 32'h10, 1'b1);
      cyc("jal_wrap");

      // reset mid-stream with flush also asserted
      drive(3'b000, 1'b0, 32'd1, 32'd2, 32'h20, 32'h40, 1'b0, 1'b1, 2'b00, 2'b00);
      rst = 1'b0; FlushE = 1'b1;
      expect_push(32'h0, 32'h0, 32'h0, 1'b0);
      cyc("rst_flush");
      chk_ctrl_zero("rst_flush");

      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL sb_drain got=%0d exp=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
